vscale_mem_port_arbiter: RTL

//  Shares one single-ported, pipelined (address phase / data phase) memory bus between the

---
 rtl/vscale_mem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vscale_mem_port_arbiter.sv
// vscale_mem_port_arbiter
//   Shares one pipelined (address phase / data phase) memory bus between the
//   instruction-fetch port and the data port. The data port wins the address
//   phase unless it has already taken MAX_DMEM_STREAK consecutive accepted
//   grants while a fetch was waiting, in which case one fetch grant is forced.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   imem_*                fetch port: addr in; wait/rdata/badmem_e out
//   dmem_*                data port: en/wen/size/addr/wdata_delayed in;
//                         wait/rdata/badmem_e out
//   bus_valid/addr/wen/size/wdata   address-phase and data-phase outputs to memory
//   bus_ready/rdata/err   memory response; bus_ready=1 both completes the data
//                         phase and accepts the current address phase
//
// Data-phase owner
//   state     | meaning
//   OWN_NONE  | no access in data phase (after reset)
//   OWN_IMEM  | fetch in data phase
//   OWN_DMEM  | data access in data phase
module vscale_mem_port_arbiter #(
  parameter int XPR_LEN         = 32,
  parameter int MEM_TYPE_WIDTH  = 3,
  parameter logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW = 3'd2,
  parameter int MAX_DMEM_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XPR_LEN-1:0]        imem_addr,
  output logic                      imem_wait,
  output logic [XPR_LEN-1:0]        imem_rdata,
  output logic                      imem_badmem_e,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [XPR_LEN-1:0]        dmem_addr,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic                      dmem_wait,
  output logic [XPR_LEN-1:0]        dmem_rdata,
  output logic                      dmem_badmem_e,
  output logic                      bus_valid,
  output logic [XPR_LEN-1:0]        bus_addr,
  output logic                      bus_wen,
  output logic [MEM_TYPE_WIDTH-1:0] bus_size,
  output logic [XPR_LEN-1:0]        bus_wdata,
  input  logic                      bus_ready,
  input  logic [XPR_LEN-1:0]        bus_rdata,
  input  logic                      bus_err
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DMEM_STREAK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  owner_e              dp_owner, dp_owner_nxt;
  logic                dp_wen, dp_wen_nxt;
  logic                d_miss, d_miss_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                adv;
  logic                g_d;
  logic                own_i, own_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_owner <= OWN_NONE;
      dp_wen   <= 1'b0;
      d_miss   <= 1'b0;
      streak   <= '0;
    end else begin
      dp_owner <= dp_owner_nxt;
      dp_wen   <= dp_wen_nxt;
      d_miss   <= d_miss_nxt;
      streak   <= streak_nxt;
    end
  end

  always_comb begin
    adv          = bus_ready & ~reset;
    // Grant depends only on held port inputs and the registered streak, so
    // the address phase stays stable across bus_ready=0 cycles.
    g_d          = dmem_en & (streak < STREAK_MAX);

    bus_valid    = ~reset;
    bus_addr     = g_d ? dmem_addr : imem_addr;
    bus_wen      = g_d & dmem_wen;
    bus_size     = g_d ? dmem_size : MEM_TYPE_LW;

    dp_owner_nxt = dp_owner;
    dp_wen_nxt   = dp_wen;
    d_miss_nxt   = d_miss;
    streak_nxt   = streak;
    if (adv) begin
      dp_owner_nxt = g_d ? OWN_DMEM : OWN_IMEM;
      dp_wen_nxt   = bus_wen;
      d_miss_nxt   = dmem_en & ~g_d;
      if (g_d)
        streak_nxt = (streak == STREAK_MAX) ? STREAK_MAX : streak + STREAK_W'(1);
      else
        streak_nxt = '0;
    end

    // Outputs are forced quiet during the reset cycle itself, when the
    // registers may still hold a stale (or unknown) data phase.
    own_i         = ~reset & (dp_owner == OWN_IMEM);
    own_d         = ~reset & (dp_owner == OWN_DMEM);

    imem_wait     = ~(own_i & bus_ready);
    dmem_wait     = ~reset & (d_miss | (own_d & ~bus_ready));
    imem_rdata    = bus_rdata;
    dmem_rdata    = bus_rdata;
    imem_badmem_e = bus_err & bus_ready & own_i;
    dmem_badmem_e = bus_err & bus_ready & own_d;
    bus_wdata     = (own_d & dp_wen) ? dmem_wdata_delayed : '0;
  end

endmodule
